// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
//   ser_state_t  : FSM state encoding (IDLE, SHIFT)
//   IDLE_BIT_DEF : default line level when no word is being sent
//   cnt_w()      : width of the bit counter for a given word width
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam logic IDLE_BIT_DEF = 1'b1;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake and serial output bundle of the serializer.
//   in_data/in_valid/in_ready : word transfer, taken when valid && ready at an edge
//   dout/dout_valid           : serial bit and its qualifier
//   frame_start               : high on the first bit of each word
//   busy                      : shifting or holding buffer occupied
// slave  = serializer side, master = word producer / serial consumer side.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, dout, dout_valid, frame_start, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, dout, dout_valid, frame_start, busy
  );
endinterface

// File: rtl/piso_serializer_hold_buf.sv
// One-entry holding buffer that lets the next word wait while the current
// word is still being shifted out.
//   clk, rst : clock, synchronous active-high reset (clears only the flag)
//   i_write  : capture i_data and mark the buffer full
//   i_drain  : mark the buffer empty (o_data has been consumed)
//   i_data   : word to store
//   o_data   : stored word
//   o_full   : buffer holds a word
module piso_serializer_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_write,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // The data word is qualified by r_full, so it needs no reset.
  always_ff @(posedge clk) begin
    if (i_write) r_data <= i_data;
  end

  // Write and drain are mutually exclusive: writes need in_ready, which is
  // low whenever the buffer is full.
  always_ff @(posedge clk) begin
    if (rst)          r_full <= 1'b0;
    else if (i_write) r_full <= 1'b1;
    else if (i_drain) r_full <= 1'b0;
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer. Takes WIDTH-bit words over a
// valid/ready handshake and sends them one bit per clock on dout, with a
// one-word holding buffer so consecutive words stream without a gap.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset; discards current and buffered word
//   sbus : piso_serializer_if.slave (word input, serial output, status)
// Parameters: WIDTH (2..32), MSB_FIRST (1 = bit WIDTH-1 first),
//             IDLE_BIT (dout level while nothing is sent).
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  piso_serializer_if.slave sbus
);

  localparam int             CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;

  logic             w_hold_full;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_hold_wr;
  logic             w_hold_drain;
  logic [WIDTH-1:0] w_shifted;

  // Ready depends only on the buffer flag and reset, never on in_valid.
  assign w_in_ready = !w_hold_full && !rst;
  assign w_accept   = sbus.in_valid && w_in_ready;
  assign w_last     = (r_cnt == LAST_CNT);

  // The buffer is only used when a word arrives mid-word; at the last bit
  // an incoming word goes straight into the shift register instead.
  assign w_hold_wr    = w_accept && (r_state == SHIFT) && !w_last;
  assign w_hold_drain = (r_state == SHIFT) && w_last && w_hold_full;

  // Move the next bit to the output end; the vacated end is don't-care.
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shreg[WIDTH-1:1]};

  piso_serializer_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_write (w_hold_wr),
    .i_drain (w_hold_drain),
    .i_data  (sbus.in_data),
    .o_data  (w_hold_data),
    .o_full  (w_hold_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= sbus.in_data;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!w_last) begin
            r_shreg <= w_shifted;
            r_cnt   <= r_cnt + 1'b1;
          end else if (w_hold_full) begin
            // Buffered word has priority; no accept is possible while full.
            r_shreg <= w_hold_data;
            r_cnt   <= '0;
          end else if (w_accept) begin
            r_shreg <= sbus.in_data;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sbus.in_ready    = w_in_ready;
  assign sbus.dout        = (r_state == SHIFT)
                            ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0])
                            : IDLE_BIT;
  assign sbus.dout_valid  = (r_state == SHIFT);
  assign sbus.frame_start = (r_state == SHIFT) && (r_cnt == '0);
  assign sbus.busy        = (r_state == SHIFT) || w_hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an 8-bit MSB-first instance, an 8-bit
// LSB-first instance and a 5-bit instance share clock and reset.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) if8 ();
  piso_serializer_if #(.WIDTH(8)) ifl ();
  piso_serializer_if #(.WIDTH(5)) if5 ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk (clk), .rst (rst), .sbus (if8)
  );
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk (clk), .rst (rst), .sbus (ifl)
  );
  piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_w5 (
    .clk (clk), .rst (rst), .sbus (if5)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       dout;
    logic       dv;
    logic       fs;
    logic       busy;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rdy,
                              input logic dout, input logic dv, input logic fs,
                              input logic busy);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.dout = dout; r.dv = dv; r.fs = fs; r.busy = busy;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic rdy, input logic dout,
                      input logic dv, input logic fs, input logic busy);
    chk({tag, ".in_ready"},    if8.in_ready,    rdy);
    chk({tag, ".dout"},        if8.dout,        dout);
    chk({tag, ".dout_valid"},  if8.dout_valid,  dv);
    chk({tag, ".frame_start"}, if8.frame_start, fs);
    chk({tag, ".busy"},        if8.busy,        busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] w8;
    logic [4:0] w5;
    logic [7:0] lsb_exp;

    rst = 1'b1;
    if8.in_valid = 1'b0; if8.in_data = '0;
    ifl.in_valid = 1'b0; ifl.in_data = '0;
    if5.in_valid = 1'b0; if5.in_data = '0;

    // Reset held for three cycles, then ten idle cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk8($sformatf("rst[%0d]", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk8($sformatf("idle[%0d]", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end

    // Single word 8'hB2, MSB first.
    w8 = 8'hB2;
    if8.in_valid = 1'b1; if8.in_data = w8;
    tick();
    if8.in_valid = 1'b0; if8.in_data = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2.bit%0d", i), if8.dout, w8[7-i]);
      chk($sformatf("b2.dv%0d", i),  if8.dout_valid, 1'b1);
      chk($sformatf("b2.fs%0d", i),  if8.frame_start, (i == 0));
      if (i < 7) tick();
    end
    tick();
    chk8("b2.end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back A5, 3C, FF with in_valid held; each row: inputs before
    // the edge, outputs after it.
    tbl[0]  = mk(1, 8'hA5, 1, 1, 1, 1, 1);
    tbl[1]  = mk(1, 8'h3C, 0, 0, 1, 0, 1);
    tbl[2]  = mk(1, 8'hFF, 0, 1, 1, 0, 1);
    tbl[3]  = mk(1, 8'hFF, 0, 0, 1, 0, 1);
    tbl[4]  = mk(1, 8'hFF, 0, 0, 1, 0, 1);
    tbl[5]  = mk(1, 8'hFF, 0, 1, 1, 0, 1);
    tbl[6]  = mk(1, 8'hFF, 0, 0, 1, 0, 1);
    tbl[7]  = mk(1, 8'hFF, 0, 1, 1, 0, 1);
    tbl[8]  = mk(1, 8'hFF, 1, 0, 1, 1, 1);
    tbl[9]  = mk(1, 8'hFF, 0, 0, 1, 0, 1);
    tbl[10] = mk(1, 8'h00, 0, 1, 1, 0, 1);
    tbl[11] = mk(1, 8'h00, 0, 1, 1, 0, 1);
    tbl[12] = mk(1, 8'h00, 0, 1, 1, 0, 1);
    tbl[13] = mk(1, 8'h00, 0, 1, 1, 0, 1);
    tbl[14] = mk(1, 8'h00, 0, 0, 1, 0, 1);
    tbl[15] = mk(1, 8'h00, 0, 0, 1, 0, 1);
    tbl[16] = mk(1, 8'h00, 1, 1, 1, 1, 1);
    tbl[17] = mk(0, 8'h00, 1, 1, 1, 0, 1);
    tbl[18] = mk(0, 8'h00, 1, 1, 1, 0, 1);
    tbl[19] = mk(0, 8'h00, 1, 1, 1, 0, 1);
    tbl[20] = mk(0, 8'h00, 1, 1, 1, 0, 1);
    tbl[21] = mk(0, 8'h00, 1, 1, 1, 0, 1);
    tbl[22] = mk(0, 8'h00, 1, 1, 1, 0, 1);
    tbl[23] = mk(0, 8'h00, 1, 1, 1, 0, 1);
    tbl[24] = mk(0, 8'h00, 1, 1, 0, 0, 0);
    for (int r = 0; r < 25; r++) begin
      if8.in_valid = tbl[r].v;
      if8.in_data  = tbl[r].d;
      tick();
      chk8($sformatf("b2b[%0d]", r), tbl[r].rdy, tbl[r].dout, tbl[r].dv,
           tbl[r].fs, tbl[r].busy);
    end
    if8.in_valid = 1'b0;

    // LSB first: 8'h01 -> 1,0,0,0,0,0,0,0.
    lsb_exp = 8'b0000_0001;
    ifl.in_valid = 1'b1; ifl.in_data = 8'h01;
    tick();
    ifl.in_valid = 1'b0; ifl.in_data = 8'hFE;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb.bit%0d", i), ifl.dout, lsb_exp[i]);
      chk($sformatf("lsb.fs%0d", i),  ifl.frame_start, (i == 0));
      tick();
    end
    chk("lsb.end.dv", ifl.dout_valid, 1'b0);
    chk("lsb.end.dout", ifl.dout, 1'b1);

    // WIDTH=5 detector feed: 01001 repeated, five words, gapless.
    w5 = 5'b01001;
    if5.in_valid = 1'b1; if5.in_data = w5;
    for (int k = 0; k < 25; k++) begin
      tick();
      chk($sformatf("w5.bit%0d", k), if5.dout, w5[4 - (k % 5)]);
      chk($sformatf("w5.dv%0d", k),  if5.dout_valid, 1'b1);
      chk($sformatf("w5.fs%0d", k),  if5.frame_start, ((k % 5) == 0));
      if (k == 16) if5.in_valid = 1'b0;
    end
    tick();
    chk("w5.end.dv", if5.dout_valid, 1'b0);
    chk("w5.end.busy", if5.busy, 1'b0);

    // Reset in the middle of F0 with 0F buffered, then send 81.
    if8.in_valid = 1'b1; if8.in_data = 8'hF0;
    tick();
    chk8("mr.f0b0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    if8.in_data = 8'h0F;
    tick();
    chk8("mr.f0b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    if8.in_valid = 1'b0; if8.in_data = 8'h00;
    tick();
    tick();
    chk8("mr.f0b3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    chk8("mr.rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("mr.ready_after", if8.in_ready, 1'b1);
    w8 = 8'h81;
    if8.in_valid = 1'b1; if8.in_data = w8;
    tick();
    if8.in_valid = 1'b0; if8.in_data = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("r81.bit%0d", i), if8.dout, w8[7-i]);
      chk($sformatf("r81.dv%0d", i),  if8.dout_valid, 1'b1);
      chk($sformatf("r81.fs%0d", i),  if8.frame_start, (i == 0));
      tick();
    end
    chk8("r81.end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    chk8("r81.quiet", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
